// File: rtl/rtc_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rtc_set_ctrl
// Brief    : Mode/edit controller for the 24-hour clock core. Walks button
//            pulses through time-set and alarm-set modes, issues the load
//            handshake to the core, owns the alarm configuration and turns
//            the core's alarm match level into a latched buzzer with snooze.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_set_ctrl #(
    parameter int SNOOZE_MIN = 5,
    parameter int TIMEOUT    = 1000,
    parameter int BLINK_DIV  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_alarm,
    input  logic       btn_snooze,
    input  logic [4:0] rtc_hour,
    input  logic [5:0] rtc_min,
    input  logic       alarm_match,
    output logic       load_en,
    output logic [4:0] load_hour,
    output logic [5:0] load_min,
    output logic [5:0] alarm_hr,
    output logic [5:0] alarm_min,
    output logic       alarm_en,
    output logic [2:0] mode,
    output logic       blink,
    output logic       buzzer
);

    localparam logic [2:0] S_RUN      = 3'd0;
    localparam logic [2:0] S_SET_HR   = 3'd1;
    localparam logic [2:0] S_SET_MIN  = 3'd2;
    localparam logic [2:0] S_SET_AHR  = 3'd3;
    localparam logic [2:0] S_SET_AMIN = 3'd4;

    localparam int c_IDLE_W = $clog2(TIMEOUT + 1);
    localparam int c_BLK_W  = $clog2(BLINK_DIV + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST   = c_IDLE_W'(TIMEOUT - 1);
    localparam logic [c_BLK_W-1:0]  c_BLK_LAST    = c_BLK_W'(BLINK_DIV - 1);
    localparam logic [3:0]          c_SNOOZE_INIT = 4'(SNOOZE_MIN);

    logic [2:0]          r_state;
    logic [4:0]          r_edit_hr;
    logic [5:0]          r_edit_min;
    logic                r_load_en;
    logic [4:0]          r_load_hour;
    logic [5:0]          r_load_min;
    logic [4:0]          r_alarm_hr;
    logic [5:0]          r_alarm_min;
    logic                r_alarm_en;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic                r_blink;
    logic [c_BLK_W-1:0]  r_blink_cnt;
    logic                r_buzzer;
    logic                r_snooze_act;
    logic [3:0]          r_snooze_cnt;
    logic                r_match_d;
    logic [5:0]          r_min_d;

    logic w_any_btn;
    logic w_step;
    logic w_match_rise;
    logic w_match_fall;
    logic w_min_tick;
    logic w_alarm_off;

    assign w_any_btn    = btn_mode | btn_up | btn_down | btn_alarm | btn_snooze;
    // Simultaneous up and down cancel out.
    assign w_step       = btn_up ^ btn_down;
    assign w_match_rise = alarm_match & ~r_match_d;
    assign w_match_fall = ~alarm_match & r_match_d;
    assign w_min_tick   = (rtc_min != r_min_d);
    assign w_alarm_off  = (r_state == S_RUN) & btn_alarm & r_alarm_en;

    // Wrapping +1/-1 on an hour (0..23) field.
    function automatic logic [4:0] f_hr_step(input logic [4:0] v, input logic up);
        if (up) f_hr_step = (v >= 5'd23) ? 5'd0 : v + 5'd1;
        else    f_hr_step = (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    // Wrapping +1/-1 on a minute (0..59) field.
    function automatic logic [5:0] f_min_step(input logic [5:0] v, input logic up);
        if (up) f_min_step = (v >= 6'd59) ? 6'd0 : v + 6'd1;
        else    f_min_step = (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    // Mode sequencing, field editing, load handshake, idle timeout and blink.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_edit_hr   <= '0;
            r_edit_min  <= '0;
            r_load_en   <= 1'b0;
            r_load_hour <= '0;
            r_load_min  <= '0;
            r_alarm_hr  <= '0;
            r_alarm_min <= '0;
            r_idle_cnt  <= '0;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else begin
            r_load_en <= 1'b0;
            if (btn_mode) begin
                // Mode change wins over any same-cycle up/down.
                r_idle_cnt  <= '0;
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
                case (r_state)
                    S_RUN: begin
                        r_state    <= S_SET_HR;
                        r_edit_hr  <= rtc_hour;
                        r_edit_min <= rtc_min;
                    end
                    S_SET_HR:  r_state <= S_SET_MIN;
                    S_SET_MIN: begin
                        r_state     <= S_SET_AHR;
                        r_load_en   <= 1'b1;
                        r_load_hour <= r_edit_hr;
                        r_load_min  <= r_edit_min;
                    end
                    S_SET_AHR: r_state <= S_SET_AMIN;
                    default: begin
                        r_state <= S_RUN;
                        r_blink <= 1'b0;
                    end
                endcase
            end else if (r_state == S_RUN) begin
                r_idle_cnt  <= '0;
                r_blink     <= 1'b0;
                r_blink_cnt <= '0;
            end else if (!w_any_btn && (r_idle_cnt == c_IDLE_LAST)) begin
                // Abandon the edit; time edits are simply never loaded,
                // alarm edits were applied in place and stay.
                r_state     <= S_RUN;
                r_idle_cnt  <= '0;
                r_blink     <= 1'b0;
                r_blink_cnt <= '0;
            end else begin
                r_idle_cnt <= w_any_btn ? '0 : r_idle_cnt + 1'b1;
                if (r_blink_cnt == c_BLK_LAST) begin
                    r_blink     <= ~r_blink;
                    r_blink_cnt <= '0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
                if (w_step) begin
                    case (r_state)
                        S_SET_HR:   r_edit_hr   <= f_hr_step(r_edit_hr, btn_up);
                        S_SET_MIN:  r_edit_min  <= f_min_step(r_edit_min, btn_up);
                        S_SET_AHR:  r_alarm_hr  <= f_hr_step(r_alarm_hr, btn_up);
                        S_SET_AMIN: r_alarm_min <= f_min_step(r_alarm_min, btn_up);
                        default: ;
                    endcase
                end
            end
        end
    end

    // Alarm enable, buzzer latch and snooze countdown; active in every mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alarm_en   <= 1'b0;
            r_buzzer     <= 1'b0;
            r_snooze_act <= 1'b0;
            r_snooze_cnt <= '0;
            r_match_d    <= 1'b0;
            r_min_d      <= '0;
        end else begin
            r_match_d <= alarm_match;
            r_min_d   <= rtc_min;
            if ((r_state == S_RUN) && btn_alarm) begin
                r_alarm_en <= ~r_alarm_en;
            end
            if (w_alarm_off) begin
                r_buzzer     <= 1'b0;
                r_snooze_act <= 1'b0;
                r_snooze_cnt <= '0;
            end else if (r_snooze_act) begin
                if (w_min_tick) begin
                    if (r_snooze_cnt <= 4'd1) begin
                        r_buzzer     <= 1'b1;
                        r_snooze_act <= 1'b0;
                        r_snooze_cnt <= '0;
                    end else begin
                        r_snooze_cnt <= r_snooze_cnt - 4'd1;
                    end
                end
            end else if (r_buzzer) begin
                if (btn_snooze) begin
                    r_buzzer     <= 1'b0;
                    r_snooze_act <= 1'b1;
                    r_snooze_cnt <= c_SNOOZE_INIT;
                end else if (w_match_fall) begin
                    r_buzzer <= 1'b0;
                end
            end else if (w_match_rise && r_alarm_en) begin
                r_buzzer <= 1'b1;
            end
        end
    end

    assign load_en   = r_load_en;
    assign load_hour = r_load_hour;
    assign load_min  = r_load_min;
    assign alarm_hr  = {1'b0, r_alarm_hr};
    assign alarm_min = r_alarm_min;
    assign alarm_en  = r_alarm_en;
    assign mode      = r_state;
    assign blink     = r_blink;
    assign buzzer    = r_buzzer;

endmodule
`default_nettype wire

// File: doc/rtc_set_ctrl.md
Name: rtc_set_ctrl

Overview:
- Mode/edit controller for the 24-hour clock core.
- Sequences user button pulses through set-time and set-alarm modes, and drives a load handshake into the clock core.
- Owns the alarm hour/minute/enable configuration.
- Turns the core's level alarm match into a latched buzzer output with snooze.

Parameters:
- SNOOZE_MIN, 5, number of minute rollovers of rtc_min before a snoozed alarm re-sounds (1..15).
- TIMEOUT, 1000, idle cycles in any edit mode before abandoning the edit and returning to RUN.
- BLINK_DIV, 4, cycles per blink half-period in edit modes.

Ports:
- clk  in  1  system clock, shared with the clock core.
- rst  in  1  synchronous active-high reset.
- btn_mode  in  1  one-cycle pulse (pre-synchronised, debounced); advances the mode.
- btn_up  in  1  one-cycle pulse; increments the field being edited.
- btn_down  in  1  one-cycle pulse; decrements the field being edited.
- btn_alarm  in  1  one-cycle pulse; toggles alarm_en, honoured in RUN only.
- btn_snooze  in  1  one-cycle pulse; silences the buzzer and starts the snooze countdown.
- rtc_hour  in  5  current hour from the clock core (0..23).
- rtc_min  in  6  current minute from the clock core (0..59).
- alarm_match  in  1  alarm level from the clock core (high during the whole matching minute).
- load_en  out  1  one-cycle pulse; core loads hour/min and clears sec.
- load_hour  out  5  hour value to load; valid when load_en is high.
- load_min  out  6  minute value to load; valid when load_en is high.
- alarm_hr  out  6  configured alarm hour (0..23, upper bit always 0).
- alarm_min  out  6  configured alarm minute (0..59).
- alarm_en  out  1  alarm enable, fed to the core.
- mode  out  3  0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_AHR, 4=SET_AMIN.
- blink  out  1  display blink for the field being edited.
- buzzer  out  1  alarm sounding.

Behaviour:
- Reset values: mode=RUN, all outputs 0, edit registers 0, timers 0.
- Inputs are sampled only on posedge clk. Reset has priority over every other input.
- State machine (btn_mode advances one step per pulse):
  - RUN -> SET_HR: copy rtc_hour/rtc_min into edit_hr/edit_min in the same cycle.
  - SET_HR -> SET_MIN.
  - SET_MIN -> SET_AHR: assert load_en for exactly one cycle, with load_hour=edit_hr and load_min=edit_min.
  - SET_AHR -> SET_AMIN.
  - SET_AMIN -> RUN.
  - alarm_hr/alarm_min are edited in place in SET_AHR/SET_AMIN.
- Field editing:
  - btn_up/btn_down change the current field by +1/-1.
  - Hour wraps 23->0 and 0->23; minute wraps 59->0 and 0->59.
  - No carry between fields.
  - up and down in the same cycle: no change.
  - btn_mode in the same cycle as up/down: the mode change wins; up/down are ignored.
- load_hour/load_min hold the last loaded values outside the load_en pulse.
- Timeout:
  - The idle counter resets on any button pulse and on entering an edit mode.
  - After TIMEOUT idle cycles in SET_HR/SET_MIN, return to RUN without load_en; the time edit is discarded.
  - In SET_AHR/SET_AMIN, the timeout returns to RUN and keeps the alarm edits already made.
- blink:
  - Toggles every BLINK_DIV cycles while in an edit mode.
  - Forced to 0 in RUN.
  - Restarts at 1 on each mode change.
- alarm_en: btn_alarm toggles it in RUN only, and is ignored in other modes. Clearing alarm_en also clears buzzer and cancels any snooze.
- Buzzer:
  - Rising edge of alarm_match (registered previous value) while alarm_en=1 -> buzzer=1 on the next cycle.
  - buzzer clears when alarm_match falls, unless snooze is active.
  - btn_snooze while buzzer=1: buzzer=0, snooze_cnt=SNOOZE_MIN, snooze active.
  - Each change of rtc_min (registered compare) decrements snooze_cnt.
  - When snooze_cnt reaches 0: buzzer=1 and snooze inactive. This repeats on each btn_snooze.
  - btn_snooze while buzzer=0 and no snooze is active: no effect.
- Buzzer and snooze logic run in all modes. Entering an edit mode does not silence the buzzer.
- Reset mid-edit returns to RUN with no load_en and the alarm cleared to 00:00, disabled.

Test Plan:
- Reset, then rtc_hour=13, rtc_min=45. Press mode, up×11 (13->0 wrap), mode, down×46 (45->59 wrap), mode -> single load_en pulse with load_hour=0, load_min=59; mode=3.
- In SET_AHR, down once (0->23). Mode, up×7, mode -> alarm_hr=23, alarm_min=7, mode=0, no load_en.
- TIMEOUT=20: enter SET_HR, up×3, idle 20 cycles -> mode=0, load_en never asserted; alarm registers unchanged.
- Same-cycle btn_up+btn_down in SET_MIN -> edit_min unchanged. btn_mode+btn_up -> mode advances, value unchanged.
- alarm_en=1, raise alarm_match -> buzzer=1 one cycle later. btn_snooze -> buzzer=0. SNOOZE_MIN=2 rtc_min changes -> buzzer=1. Drop alarm_match -> buzzer=0.
- btn_alarm in SET_HR -> alarm_en unchanged. In RUN while buzzing -> alarm_en=0 and buzzer=0 next cycle. Assert rst mid-SET_MIN -> all outputs 0 next cycle.
